// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared types and widths for the seven-segment display arbiter
package seg_disp_pkg;

    localparam int DIGIT_W = 4;
    localparam int DISP_W  = 4 * DIGIT_W;

    typedef enum logic {IDLE, SHOW} disp_state_t;
    typedef logic [DISP_W-1:0] disp_word_t;

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// rtl/seg_display_arbiter_rr_pick.sv - round-robin first-set-bit picker with wrap-around
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int               j;
    logic [IDX_W-1:0] jj;

    // Walk offsets from far to near so the nearest hit to start is the last write.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = 0;
        jj     = '0;
        for (int off = N - 1; off >= 0; off--) begin
            j = int'(start) + off;
            if (j >= N) begin
                j = j - N;
            end
            jj = IDX_W'(j);
            if (mask[jj]) begin
                onehot     = '0;
                onehot[jj] = 1'b1;
                idx        = jj;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin sharing of one 4-digit display between sources
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter  int NUM_SRC      = 4,
    parameter  int DWELL_CYCLES = 50_000_000,
    localparam int CNT_W        = $clog2(DWELL_CYCLES),
    localparam int IDX_W        = $clog2(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    req,
    input  logic [NUM_SRC*16-1:0] src_data,
    input  logic                  lock,
    output logic [15:0]           disp_data,
    output logic                  disp_valid,
    output logic [NUM_SRC-1:0]    grant,
    output logic [IDX_W-1:0]      cur_src,
    output logic [NUM_SRC-1:0]    ack
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_SRC - 1);

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_MAX) ? '0 : i + 1'b1;
    endfunction

    disp_state_t          state_q, state_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [NUM_SRC-1:0]   ack_q, ack_d;
    logic [IDX_W-1:0]     cur_q, cur_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    disp_word_t           data_q, data_d;

    disp_word_t           words [NUM_SRC];
    logic [IDX_W-1:0]     pick_start;
    logic [NUM_SRC-1:0]   pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 take;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_words
        assign words[i] = src_data[i*DISP_W +: DISP_W];
    end

    // In SHOW both the drop and the rotation paths search from the slot after the current grant.
    assign pick_start = (state_q == SHOW) ? next_idx(cur_q) : ptr_q;

    rr_pick #(.N(NUM_SRC), .IDX_W(IDX_W)) u_pick (
        .mask   (req),
        .start  (pick_start),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cur_d   = cur_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ack_d   = '0;
        take    = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                take    = pick_valid;
            end
            SHOW: begin
                data_d = words[cur_q];
                cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if ((req & grant_q) == '0) begin
                    if (pick_valid) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        data_d  = data_q;
                    end
                end else if (cnt_q == CNT_MAX && !lock) begin
                    if (pick_onehot != grant_q) begin
                        take = 1'b1;
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d = SHOW;
            grant_d = pick_onehot;
            ack_d   = pick_onehot;
            cur_d   = pick_idx;
            ptr_d   = next_idx(pick_idx);
            data_d  = words[pick_idx];
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            cur_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            cur_q   <= cur_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign disp_data  = data_q;
    assign disp_valid = |grant_q;
    assign grant      = grant_q;
    assign cur_src    = cur_q;
    assign ack        = ack_q;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
    a_ack_in_grant:  assert property (@(posedge clk) disable iff (!rst_n) (ack_q & ~grant_q) == '0);
    a_valid_match:   assert property (@(posedge clk) disable iff (!rst_n) disp_valid == |grant_q);
    a_grant_had_req: assert property (@(posedge clk) disable iff (!rst_n) (grant_q & ~$past(req)) == '0);

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the single 4-digit seven-segment display between up to NUM_SRC requesters, for example the CPU output register, a debug PC tap and a status word.
- Round-robin arbitration with a minimum dwell time per grant, so each value stays readable.
- The 16-bit output feeds the seven-segment driver's din input directly.
- Sits between the datapath/IO registers and the display driver.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DWELL_CYCLES, 50_000_000, clock cycles one source is shown before rotation (1 s at 50 MHz); must be ≥ 2.
- CNT_W, $clog2(DWELL_CYCLES), dwell counter width (derived; do not override).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_SRC  level request per source; held high while the source wants display time.
- src_data  input  NUM_SRC×16  packed 16-bit display word per source; index i = bits [16i+15:16i].
- lock  input  1  when high, freezes rotation on the current grant.
- disp_data  output  16  word to the seven-segment driver din.
- disp_valid  output  1  high while some source is granted.
- grant  output  NUM_SRC  one-hot current grant; all-zero when idle.
- cur_src  output  $clog2(NUM_SRC)  index of the granted source; holds the last value when idle.
- ack  output  NUM_SRC  one-cycle pulse on the bit of a newly granted source.

Behaviour:
- Reset (async assert, sync deassert by the user):
  - disp_data=16'h0000, disp_valid=0, grant=0, cur_src=0, ack=0.
  - RR pointer=0, dwell counter=0, state IDLE.
  - Reset mid-operation drops the grant immediately.
- States: IDLE, SHOW.
- Arbitration (combinational):
  - Pick the first set bit of the candidate mask, searching upward from the RR pointer with wrap-around.
  - After any grant, pointer = granted index + 1 mod NUM_SRC.
- IDLE:
  - On a cycle with req≠0: grant the arbitration winner at that edge.
  - Load disp_data from the winner's src_data, set disp_valid=1, pulse ack, clear the counter, go to SHOW.
  - Latency: req sampled at edge k → grant/disp_data valid after edge k.
  - With req=0: disp_valid=0; disp_data and cur_src hold their last values.
- SHOW, every cycle:
  - disp_data <= src_data of the granted source (1-cycle registered tracking of live value changes).
  - Counter increments and saturates at DWELL_CYCLES-1.
- SHOW, granted req drops (highest priority):
  - Re-arbitrate among the remaining requesters in the same cycle.
  - If a winner exists: grant it, pulse ack, clear the counter.
  - If none: go to IDLE with grant=0 and disp_valid=0.
- SHOW, dwell expiry (counter==DWELL_CYCLES-1, lock=0, req still high):
  - Arbitrate with the search starting at cur_src+1.
  - A different winner: switch, pulse ack, clear the counter.
  - Only the current source requesting: keep the grant, clear the counter, no ack.
- lock=1:
  - No rotation; the counter holds at saturation.
  - On lock release with the counter saturated, rotation is evaluated on the next edge.
  - A req drop still ends the grant regardless of lock.
- Simultaneous events:
  - Dwell expiry and granted-req drop in the same cycle are treated as a drop.
  - New requests arriving mid-dwell never preempt the grant.
- Invariants checked by assertions:
  - grant is zero or one-hot.
  - ack ⊆ grant.
  - disp_valid == |grant.
  - A granted source is always one with req high the previous cycle.

Decomposition:
- Package seg_disp_pkg:
  - DISP_W=16 and DIGIT_W=4.
  - typedef enum logic {IDLE, SHOW} disp_state_t.
  - typedef logic [DISP_W-1:0] disp_word_t.
- Sub-module rr_pick (combinational):
  - Inputs: mask and start pointer.
  - Outputs: one-hot winner, winner index, any-valid flag.
  - Instantiated once; reused for both the IDLE arbitration and the SHOW re-arbitration paths via the start-pointer mux.

Test Plan (DWELL_CYCLES=4, NUM_SRC=4):
1. Reset then req=4'b0000 for 10 cycles → disp_valid=0, grant=0, disp_data=16'h0000, ack never pulses.
2. src_data[2]=16'h1234, req=4'b0100 → next edge: grant=4'b0100, cur_src=2, ack=4'b0100 for one cycle, disp_data=16'h1234. Change src_data[2] to 16'hBEEF → disp_data=16'hBEEF one cycle later.
3. req=4'b1011 held → grant sequence 0001,0010,1000,0001, each held exactly 4 cycles, with an ack pulse at each switch.
4. Granted source 1 with lock=1, req=4'b0011, for 20 cycles → grant stays 4'b0010. Release lock → grant=4'b0001 on the next edge.
5. Source 3 granted; drop req[3] at cycle 2 of dwell while req[0]=1 → grant=4'b0001 next edge, ack=4'b0001. Drop all reqs → disp_valid=0 and disp_data holds its last value.
6. Assert rst_n=0 mid-SHOW, asynchronously between edges → outputs reach reset values immediately without a clock. After release with req=4'b1000 → first grant=4'b1000, since the RR pointer restarts at 0.
